// File: rtl/serial_byte_receiver_if.sv
// Word delivery bus between the serial receiver and its consumer.
// The receiver (master) presents a completed word with a valid flag; the
// consumer (slave) takes it by raising wordAck on any clock edge where
// wordValid is high.
interface serial_byte_receiver_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] wordOut;
  logic              wordValid;
  logic              wordAck;

  modport master (
    output wordOut,
    output wordValid,
    input  wordAck
  );

  modport slave (
    input  wordOut,
    input  wordValid,
    output wordAck
  );
endinterface

// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver
// Receive side of the three-wire inter-station link (data, link clock,
// readyToTransmit). The remote link clock, data and ready lines are
// synchronised into the local clk domain, bits are shifted in MSB first on
// each synchronised link-clock rising edge, and each completed word is
// handed to the consumer through a one-entry holding register with a
// valid/ack handshake.
// Optional feature macro: PARITY_CHECK_EN -- adds a trailing even-parity bit
// to every frame; a word is only delivered when its parity matches.
module serial_byte_receiver #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serClk,
  input  logic                   serData,
  input  logic                   serReady,
  serial_byte_receiver_if.master word_bus,
  output logic                   busy,
  output logic [2:0]             bitCount,
  output logic                   overrun,
  output logic                   frameErr
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int CNT_W = ($clog2(FRAME_BITS + 1) > 3) ? $clog2(FRAME_BITS + 1) : 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES-1:0] rdy_sync_q, rdy_sync_d;
  logic                   s_clk_prev_q, s_clk_prev_d;
  logic                   s_rdy_prev_q, s_rdy_prev_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic                   s_clk, s_data, s_rdy;
  logic                   clk_rise, rdy_rise;
  logic                   load_en;
  logic [DATA_W-1:0]      load_word;

  assign s_clk    = clk_sync_q[SYNC_STAGES-1];
  assign s_data   = data_sync_q[SYNC_STAGES-1];
  assign s_rdy    = rdy_sync_q[SYNC_STAGES-1];
  assign clk_rise = s_clk & ~s_clk_prev_q;
  assign rdy_rise = s_rdy & ~s_rdy_prev_q;

  // Shift the asynchronous link lines through their synchroniser chains and keep the previous synchronised levels for edge detection
  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], serClk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], serData};
    rdy_sync_d   = {rdy_sync_q[SYNC_STAGES-2:0], serReady};
    s_clk_prev_d = s_clk;
    s_rdy_prev_d = s_rdy;
  end

  // Frame FSM: wait for ready to rise, shift bits on each link-clock edge, then hold off until ready drops again
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    load_en     = 1'b0;
    load_word   = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (rdy_rise) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      ST_SHIFT: begin
        if (clk_rise) begin
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
`ifdef PARITY_CHECK_EN
            if ((^shreg_q) == s_data) begin
              load_en   = 1'b1;
              load_word = shreg_q;
            end else begin
              frame_err_d = 1'b1;
            end
`else
            load_en   = 1'b1;
            load_word = {shreg_q[DATA_W-2:0], s_data};
`endif
          end else begin
            shreg_d = {shreg_q[DATA_W-2:0], s_data};
            cnt_d   = cnt_q + CNT_W'(1);
            if (!s_rdy) begin
              frame_err_d = 1'b1;
              cnt_d       = '0;
              state_d     = ST_IDLE;
            end
          end
        end else if (!s_rdy) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!s_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holding register: a new word always wins over an ack; loading over an unacked word latches the sticky overrun flag
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load_en) begin
      word_d  = load_word;
      valid_d = 1'b1;
      if (valid_q && !word_bus.wordAck) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && word_bus.wordAck) begin
      valid_d = 1'b0;
    end
  end

  // All state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      clk_sync_q   <= '0;
      data_sync_q  <= '0;
      rdy_sync_q   <= '0;
      s_clk_prev_q <= 1'b0;
      s_rdy_prev_q <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      rdy_sync_q   <= rdy_sync_d;
      s_clk_prev_q <= s_clk_prev_d;
      s_rdy_prev_q <= s_rdy_prev_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign word_bus.wordOut   = word_q;
  assign word_bus.wordValid = valid_q;
  assign busy               = (state_q == ST_SHIFT);
  assign bitCount           = cnt_q[2:0];
  assign overrun            = overrun_q;
  assign frameErr           = frame_err_q;

endmodule
